// File: rtl/rrf_commit_ctrl.sv
// ============================================================================
// rrf_commit_ctrl
// ----------------------------------------------------------------------------
// In-order commit controller for the rename register file (RRF). Each cycle
// it looks at the oldest one or two in-flight entries (at comptr and
// comptr+1) and decides how many of them retire. It advances the commit
// pointer by that amount. A committed halt stops all further commits until
// reset.
//
// Build option:
//   RRF_COMMIT_DUAL_EN  defined   -> up to two commits per cycle
//                       undefined -> single commit per cycle; slot 2 inputs
//                                    (fin2, st2, halt2) are ignored and
//                                    com2_en is tied low
//
// Parameters:
//   RRF_NUM      number of RRF entries (power of two)
//   RRF_SEL      tag width, log2(RRF_NUM)
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous active-low reset
//   freenum      free-entry count from the freelist manager (0..RRF_NUM)
//   prmiss       branch-mispredict flush strobe; blocks commit this cycle
//   fin1/fin2    finished bits of the entries at comptr / comptr+1
//   st1/st2      entry at comptr / comptr+1 is a store
//   halt1/halt2  entry at comptr / comptr+1 is a halt
//   stbuf_ready  store buffer can take one store commit this cycle
//   comnum       number of entries committed this cycle (0..2), combinational
//   com1_en      slot 1 commits this cycle, combinational
//   com2_en      slot 2 commits this cycle, combinational
//   st_commit    one store is released to the store buffer this cycle
//   comptr       registered tag of the oldest uncommitted entry
//   halted       registered, high once a halt has committed
// ============================================================================
module rrf_commit_ctrl #(
    parameter int RRF_NUM = 64,
    parameter int RRF_SEL = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [RRF_SEL:0]   freenum,
    input  logic               prmiss,
    input  logic               fin1,
    input  logic               fin2,
    input  logic               st1,
    input  logic               st2,
    input  logic               halt1,
    input  logic               halt2,
    input  logic               stbuf_ready,
    output logic [1:0]         comnum,
    output logic               com1_en,
    output logic               com2_en,
    output logic               st_commit,
    output logic [RRF_SEL-1:0] comptr,
    output logic               halted
);

    // ------------------------------------------------------------------------
    // Controller state
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam logic [RRF_SEL:0] RRF_NUM_W = (RRF_SEL + 1)'(RRF_NUM);
    localparam logic [RRF_SEL:0] TWO_W     = (RRF_SEL + 1)'(2);

    state_e             state_q,  state_d;
    logic [RRF_SEL-1:0] comptr_q, comptr_d;
    logic               halted_q, halted_d;

    // ------------------------------------------------------------------------
    // Occupancy
    // ------------------------------------------------------------------------
    // The freelist reports free entries; the in-flight count is the rest.
    // Kept one bit wider than a tag so a completely full RRF is representable.
    logic [RRF_SEL:0] used;
    logic             has_one;
    logic             has_two;

    assign used    = RRF_NUM_W - freenum;
    assign has_one = (used != '0);
    assign has_two = (used >= TWO_W);

    // ------------------------------------------------------------------------
    // Commit qualification
    // ------------------------------------------------------------------------
    // Gating on reset as well as state keeps the combinational outputs low
    // for the whole time reset is held, not just from the next clock.
    // A mispredict freezes commit because the freelist reads comptr that
    // cycle to rebuild its state.
    logic commit_window;
    logic slot1_ok;
    logic slot2_ok;
    logic halt_commit;

    assign commit_window = (state_q == ST_RUN) && reset && !prmiss;

    // Slot 1 needs a finished entry and, if it is a store, room in the
    // store buffer.
    assign slot1_ok = commit_window && has_one && fin1 &&
                      (!st1 || stbuf_ready);

`ifdef RRF_COMMIT_DUAL_EN
    // Slot 2 retires only behind slot 1. A halt in slot 1 must be the last
    // thing committed, and the store buffer takes at most one store per
    // cycle, so two stores can never retire together.
    assign slot2_ok = slot1_ok && has_two && fin2 && !halt1 &&
                      !(st1 && st2) && (!st2 || stbuf_ready);

    assign halt_commit = (slot1_ok && halt1) || (slot2_ok && halt2);
`else
    // Single-commit build: the second slot never retires and its inputs
    // are intentionally left unobserved.
    logic unused_slot2;

    assign unused_slot2 = fin2 ^ st2 ^ halt2;
    assign slot2_ok     = 1'b0;
    assign halt_commit  = slot1_ok && halt1;
`endif

    // ------------------------------------------------------------------------
    // Commit outputs
    // ------------------------------------------------------------------------
    assign com1_en   = slot1_ok;
    assign com2_en   = slot2_ok;
    assign comnum    = {1'b0, slot1_ok} + {1'b0, slot2_ok};
    assign st_commit = (slot1_ok && st1) || (slot2_ok && st2);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every variable driven here gets a default before the case, so
    // no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        comptr_d = comptr_q;
        halted_d = halted_q;

        case (state_q)
            ST_IDLE: begin
                // One settling cycle after reset before any commit.
                state_d = ST_RUN;
            end

            ST_RUN: begin
                // RRF_NUM is a power of two, so truncating the sum to a
                // tag width gives the modulo wrap (RRF_NUM-1 + 1 -> 0).
                comptr_d = comptr_q + RRF_SEL'(comnum);
                if (halt_commit) begin
                    state_d  = ST_HALTED;
                    halted_d = 1'b1;
                end
            end

            ST_HALTED: begin
                // Terminal until reset; nothing commits, comptr holds.
                state_d  = ST_HALTED;
                halted_d = 1'b1;
            end

            default: begin
                // Unused encoding: fall back to a safe non-committing state.
                state_d  = ST_IDLE;
                halted_d = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    // NOTE: non-blocking assignments so every register samples the values
    // from before this edge, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            comptr_q <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            comptr_q <= comptr_d;
            halted_q <= halted_d;
        end
    end

    assign comptr = comptr_q;
    assign halted = halted_q;

endmodule

// File: tb/tb_rrf_commit_ctrl.sv
// ============================================================================
// tb_rrf_commit_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for rrf_commit_ctrl. A behavioural model walks the two
// oldest entries in order and retires as many as the rules allow. A compare
// process checks every DUT output against it on each falling edge. A
// directed sequence pins known literal results, then randomized traffic with
// occasional mispredicts, halts and resets follows.
// ============================================================================
module tb_rrf_commit_ctrl;

    localparam int RRF_NUM = 64;
    localparam int RRF_SEL = 6;
`ifdef RRF_COMMIT_DUAL_EN
    localparam int SLOTS = 2;
`else
    localparam int SLOTS = 1;
`endif

    logic               clk         = 1'b0;
    logic               reset       = 1'b0;
    logic [RRF_SEL:0]   freenum     = 7'd64;
    logic               prmiss      = 1'b0;
    logic               fin1        = 1'b0;
    logic               fin2        = 1'b0;
    logic               st1         = 1'b0;
    logic               st2         = 1'b0;
    logic               halt1       = 1'b0;
    logic               halt2       = 1'b0;
    logic               stbuf_ready = 1'b0;
    logic [1:0]         comnum;
    logic               com1_en;
    logic               com2_en;
    logic               st_commit;
    logic [RRF_SEL-1:0] comptr;
    logic               halted;

    int n_tests = 0;
    int n_fail  = 0;

    rrf_commit_ctrl #(
        .RRF_NUM (RRF_NUM),
        .RRF_SEL (RRF_SEL)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .freenum     (freenum),
        .prmiss      (prmiss),
        .fin1        (fin1),
        .fin2        (fin2),
        .st1         (st1),
        .st2         (st2),
        .halt1       (halt1),
        .halt2       (halt2),
        .stbuf_ready (stbuf_ready),
        .comnum      (comnum),
        .com1_en     (com1_en),
        .com2_en     (com2_en),
        .st_commit   (st_commit),
        .comptr      (comptr),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    bit m_started = 1'b0;   // at least one edge seen since reset release
    bit m_halted  = 1'b0;
    int m_ptr     = 0;

    // Retire the oldest entries in order: stop at the first one that is not
    // present or not finished, or that is a store with no store buffer
    // capacity left. A halt is always the last entry retired.
    function automatic void model_eval(output int n, output bit st_rel,
                                       output bit hlt);
        int used;
        int stores_left;
        bit fin[2];
        bit st[2];
        bit hl[2];
        n      = 0;
        st_rel = 1'b0;
        hlt    = 1'b0;
        if (!reset || !m_started || m_halted || prmiss) return;
        used        = RRF_NUM - int'(freenum);
        fin         = '{fin1, fin2};
        st          = '{st1, st2};
        hl          = '{halt1, halt2};
        stores_left = stbuf_ready ? 1 : 0;
        for (int k = 0; k < SLOTS; k++) begin
            if (k >= used || !fin[k]) break;
            if (st[k]) begin
                if (stores_left == 0) break;
                stores_left--;
                st_rel = 1'b1;
            end
            n++;
            if (hl[k]) begin
                hlt = 1'b1;
                break;
            end
        end
    endfunction

    always @(posedge clk or negedge reset) begin
        int n;
        bit s;
        bit h;
        if (!reset) begin
            m_started <= 1'b0;
            m_halted  <= 1'b0;
            m_ptr     <= 0;
        end else if (!m_started) begin
            m_started <= 1'b1;
        end else begin
            model_eval(n, s, h);
            m_ptr <= (m_ptr + n) % RRF_NUM;
            if (h) m_halted <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Cycle-by-cycle comparison against the model
    // ------------------------------------------------------------------------
    initial begin
        int n;
        bit s;
        bit h;
        forever begin
            @(negedge clk);
            model_eval(n, s, h);
            check("m_comnum",    comnum,    n);
            check("m_com1_en",   com1_en,   (n >= 1) ? 1 : 0);
            check("m_com2_en",   com2_en,   (n == 2) ? 1 : 0);
            check("m_st_commit", st_commit, s);
            check("m_comptr",    comptr,    m_ptr);
            check("m_halted",    halted,    m_halted);
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    task automatic set_in(input int fn, input bit pm, input bit f1,
                          input bit f2, input bit s1, input bit s2,
                          input bit h1, input bit h2, input bit sb);
        freenum     = 7'(fn);
        prmiss      = pm;
        fin1        = f1;
        fin2        = f2;
        st1         = s1;
        st2         = s2;
        halt1       = h1;
        halt2       = h2;
        stbuf_ready = sb;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_ptr;

        // Reset state
        set_in(64, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) tick;
        @(negedge clk);
        check("rst_comptr", comptr, 0);
        check("rst_halted", halted, 0);
        check("rst_comnum", comnum, 0);

        // Release reset; first cycle is IDLE and must not commit.
        tick;
        reset = 1'b1;
        set_in(60, 0, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("idle_comnum", comnum, 0);
        tick;
        check("idle_comptr", comptr, 0);

        // Dual commit (single build: one per cycle), comptr 0 -> SLOTS ...
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("dual_comnum", comnum, SLOTS);
            tick;
            check("dual_comptr", comptr, SLOTS * (i + 1));
        end
        exp_ptr = 4 * SLOTS;

        // used=1: only slot 1 may retire; walk comptr up to 63.
        set_in(63, 0, 1, 1, 0, 0, 0, 0, 0);
        for (int i = exp_ptr; i < 63; i++) begin
            @(negedge clk);
            check("near_empty_comnum", comnum, 1);
            tick;
        end
        check("wrap_pre_comptr", comptr, 63);

        // Wrap-around from 63
        set_in(62, 0, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("wrap_comnum", comnum, SLOTS);
        tick;
        exp_ptr = (63 + SLOTS) % RRF_NUM;
        check("wrap_comptr", comptr, exp_ptr);

        // Freelist full: nothing in flight
        set_in(64, 0, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("empty_comnum", comnum, 0);
        tick;
        check("empty_comptr", comptr, exp_ptr);

        // Mispredict freezes commit and comptr
        set_in(60, 1, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("prmiss_comnum", comnum, 0);
        tick;
        check("prmiss_comptr", comptr, exp_ptr);

        // Two stores: only one may go to the store buffer
        set_in(60, 0, 1, 1, 1, 1, 0, 0, 1);
        @(negedge clk);
        check("st_comnum", comnum, 1);
        check("st_commit", st_commit, 1);
        tick;
        exp_ptr = (exp_ptr + 1) % RRF_NUM;
        check("st_comptr", comptr, exp_ptr);

        set_in(60, 0, 1, 1, 1, 1, 0, 0, 0);
        @(negedge clk);
        check("st_block_comnum", comnum, 0);
        check("st_block_commit", st_commit, 0);
        tick;

        // Halt in slot 2 (ignored in the single build)
        set_in(60, 0, 1, 1, 0, 0, 0, 1, 0);
        @(negedge clk);
        check("halt2_comnum", comnum, SLOTS);
        tick;
        check("halt2_halted", halted, SLOTS - 1);

        // Halt in slot 1: commits only if not already halted
        set_in(60, 0, 1, 1, 0, 0, 1, 0, 0);
        @(negedge clk);
        check("halt1_comnum", comnum, 2 - SLOTS);
        tick;
        check("halt_halted", halted, 1);

        set_in(60, 0, 1, 1, 0, 0, 0, 0, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("halted_comnum", comnum, 0);
            check("halted_stays", halted, 1);
            tick;
        end

        // Asynchronous reset while halted
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_halted", halted, 0);
        check("async_rst_comptr", comptr, 0);
        check("async_rst_comnum", comnum, 0);
        tick;
        tick;
        reset = 1'b1;

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            int r;
            int fn;
            tick;
            if (!reset) reset = 1'b1;
            else if ($urandom_range(0, 39) == 0) reset = 1'b0;
            r = $urandom_range(0, 9);
            case (r)
                0:       fn = 64;
                1:       fn = 63;
                2:       fn = 62;
                default: fn = $urandom_range(0, 64);
            endcase
            set_in(fn,
                   $urandom_range(0, 9) == 0,
                   $urandom_range(0, 3) != 0,
                   $urandom_range(0, 3) != 0,
                   $urandom_range(0, 9) < 3,
                   $urandom_range(0, 9) < 3,
                   $urandom_range(0, 49) == 0,
                   $urandom_range(0, 49) == 0,
                   $urandom_range(0, 1) == 1);
        end
        tick;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
